svc_soc_io_arb: RTL
===================

Name: svc_soc_io_arb

Overview:
- Arbiter that shares the single SoC I/O register bus (io_wen/io_waddr/io_wdata/io_wstrb/io_ren/io_raddr/io_rdata) between NREQ requesters, e.g. the RISC-V core and a debug/loader master.
- Round-robin grant with valid/ready handshake, pipelined read-response return and optional bus lock for atomic multi-access sequences.
- Lock is protected by a watchdog.
- Sits between the requesters and the I/O register bank inside the SoC simulation top.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width; strobe width is DW/8.
- RD_LAT, 1, I/O read latency in cycles: 0 = combinational (SRAM-style), 1 = registered (BRAM-style).
- LOCK_MAX, 256, maximum cycles a lock may be held; 0 disables the lock watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  request valid, one per requester
- req_ready  out  NREQ  request accepted this cycle
- req_write  in  NREQ  1 = write, 0 = read
- req_lock  in  NREQ  keep the grant after this transfer
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- req_wstrb  in  NREQ*DW/8  packed byte strobes
- rsp_valid  out  NREQ  read data valid for requester i
- rsp_rdata  out  DW  read data, shared by all requesters, qualified by rsp_valid
- io_wen  out  1  I/O write enable
- io_waddr  out  AW  I/O write address
- io_wdata  out  DW  I/O write data
- io_wstrb  out  DW/8  I/O write strobes
- io_ren  out  1  I/O read enable
- io_raddr  out  AW  I/O read address
- io_rdata  in  DW  I/O read data
- lock_err  out  1  one-cycle pulse when the lock watchdog forces a release

Behaviour:
- Reset: synchronous on clk while rst_n=0.
  - req_ready=0, rsp_valid=0, io_wen=0, io_ren=0, lock_err=0.
  - RR pointer=0, so requester 0 has highest priority first; state=ARB; read pipeline cleared.
  - A read pending when reset asserts is dropped; no rsp_valid is ever produced for it.
- Handshake:
  - Transfer occurs when req_valid[i] & req_ready[i].
  - Requester holds valid and payload stable until ready; valid must not depend on ready.
  - req_ready is combinational from the current grant and req_valid.
  - At most one req_ready bit per cycle.
- State ARB:
  - Grant the first valid requester scanning from the RR pointer upward, with wrap-around.
  - On the transfer, the RR pointer becomes granted+1 mod NREQ.
  - If req_lock[g]=1 on the accepted transfer, go to LOCKED(g) and load the lock counter with 0.
- State LOCKED(g):
  - Only requester g may be granted; all other req_ready bits are 0.
  - The lock counter increments every cycle.
  - A transfer from g with req_lock=0 returns to ARB.
  - If LOCK_MAX>0 and the counter reaches LOCK_MAX-1 without release, return to ARB next cycle and pulse lock_err for one cycle.
  - A transfer from g in that same cycle is still accepted.
- Bus drive (combinational mux of the granted requester):
  - Write: io_wen=1 with io_waddr/io_wdata/io_wstrb.
  - Read: io_ren=1 with io_raddr.
  - io_ren and io_wen are never both 1. Idle outputs: enables 0, address/data 0.
- Read return:
  - RD_LAT=0: rsp_valid[g]=1 in the transfer cycle; rsp_rdata=io_rdata.
  - RD_LAT=1: a one-entry pipeline registers the owner; rsp_valid[owner]=1 exactly one cycle after the transfer; rsp_rdata=io_rdata.
  - Back-to-back reads from any requesters are accepted every cycle; responses return strictly in order, one per cycle.
  - A write transfer in the cycle a read response returns is allowed.
- No backpressure on responses; requesters must accept rsp_valid.
- Throughput: one transfer per cycle, zero arbitration bubbles.

Decomposition:
- Shared package svc_soc_io_pkg holds:
  - state enum (ARB, LOCKED);
  - RD_LAT_COMB=0 and RD_LAT_REG=1 constants;
  - the width of the requester index, computed as $clog2(NREQ) with a floor of 1.
- One natural sub-module: svc_rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: request vector and pointer. Output: one-hot grant.
  - Reused by future bus arbiters.

Test Plan:
- Reset then req_valid=2'b11, both reads, RD_LAT=1 -> grants 0,1,0,1 on consecutive cycles; rsp_valid follows one cycle later to the matching requester with io_rdata.
- Requester 1 locks, with req_lock=1 on 3 transfers, while requester 0 valid throughout -> req_ready[0]=0 for those cycles; requester 0 is granted the cycle after the transfer with req_lock=0.
- LOCK_MAX=8, requester 0 locks then idles -> lock_err pulses at cycle 8 after the lock; requester 1 is granted the next cycle.
- RD_LAT=0, requester 0 writes addr 0x10 data 0xA5 wstrb 4'b0001, then reads 0x10 -> io_wen cycle then io_ren cycle; rsp_valid[0] in the read cycle with rsp_rdata=io_rdata.
- Read accepted from requester 1, rst_n low next cycle -> rsp_valid stays 0, io_* enables 0; after reset the first grant goes to requester 0.
- Randomized valid/write mix, 10k cycles, scoreboard -> no lost or duplicated transfers, one-hot req_ready, responses in order.

Source files
------------

// File: rtl/svc_soc_io_pkg.sv
// Shared types and constants for the SoC I/O bus arbiter family.
//   arb_state_e : arbiter state (free round-robin or locked to one owner)
//   RD_LAT_*    : supported I/O read latencies
//   idx_width() : requester index width, $clog2(n) with a floor of 1
package svc_soc_io_pkg;

    typedef enum logic [0:0] {
        StArb    = 1'b0,
        StLocked = 1'b1
    } arb_state_e;

    localparam int unsigned RD_LAT_COMB = 0;
    localparam int unsigned RD_LAT_REG  = 1;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/svc_rr_pick.sv
// Combinational round-robin priority picker.
//   req : request vector
//   ptr : index of the highest-priority requester (must be < N)
//   gnt : one-hot grant, first set bit of req scanning upward from ptr with wrap
module svc_rr_pick
    import svc_soc_io_pkg::*;
#(
    parameter int unsigned N  = 2,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] mask;
    logic [N-1:0] hi;
    logic [N-1:0] sel;

    always_comb begin
        // Requests at or above ptr win; otherwise wrap to the lowest request.
        mask = ~((N'(1) << ptr) - N'(1));
        hi   = req & mask;
        sel  = (|hi) ? hi : req;
        // Isolate the lowest set bit.
        gnt  = sel & (~sel + N'(1));
    end

endmodule

// File: rtl/svc_soc_io_arb.sv
// Arbiter sharing the SoC I/O register bus between NREQ requesters.
//   req_*     : per-requester valid/ready request channel (packed payloads)
//   rsp_*     : read responses, rsp_rdata shared and qualified by rsp_valid
//   io_*      : single I/O register bus (separate write and read ports)
//   lock_err  : one-cycle pulse when the lock watchdog forces a release
// Round-robin grant, optional bus lock held by the owner, watchdog on lock.
module svc_soc_io_arb
    import svc_soc_io_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned LOCK_MAX = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [NREQ*AW-1:0]     req_addr,
    input  logic [NREQ*DW-1:0]     req_wdata,
    input  logic [NREQ*DW/8-1:0]   req_wstrb,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DW-1:0]          rsp_rdata,
    output logic                   io_wen,
    output logic [AW-1:0]          io_waddr,
    output logic [DW-1:0]          io_wdata,
    output logic [DW/8-1:0]        io_wstrb,
    output logic                   io_ren,
    output logic [AW-1:0]          io_raddr,
    input  logic [DW-1:0]          io_rdata,
    output logic                   lock_err
);

    localparam int unsigned IW = idx_width(NREQ);
    localparam int unsigned SW = DW / 8;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]   lock_cnt_q, lock_cnt_d;

    logic [NREQ-1:0] rr_gnt;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gidx;
    logic            xfer;
    logic            g_write;
    logic            g_lock;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_wdata;
    logic [SW-1:0]   g_wstrb;
    logic            timeout;

    svc_rr_pick #(
        .N (NREQ)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt)
    );

    // Grant and payload mux. Outputs are held quiet while reset is asserted.
    always_comb begin
        gnt = '0;
        if (rst_n) begin
            if (state_q == StArb) gnt = rr_gnt;
            else                  gnt = req_valid & (NREQ'(1) << owner_q);
        end
        gidx    = '0;
        g_write = 1'b0;
        g_lock  = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        g_wstrb = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gidx    = IW'(i);
                g_write = req_write[i];
                g_lock  = req_lock[i];
                g_addr  = req_addr[i*AW +: AW];
                g_wdata = req_wdata[i*DW +: DW];
                g_wstrb = req_wstrb[i*SW +: SW];
            end
        end
        xfer = |gnt;
    end

    assign timeout = rst_n && (LOCK_MAX > 0) && (state_q == StLocked) &&
                     (lock_cnt_q == LOCK_MAX - 1);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        lock_err   = 1'b0;
        if (xfer) rr_ptr_d = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
        case (state_q)
            StArb: begin
                if (xfer && g_lock) begin
                    state_d    = StLocked;
                    owner_d    = gidx;
                    lock_cnt_d = '0;
                end
            end
            StLocked: begin
                lock_cnt_d = lock_cnt_q + 32'd1;
                if (xfer && !g_lock) begin
                    state_d = StArb;
                end else if (timeout) begin
                    // Forced release; a transfer from the owner this cycle still goes through.
                    state_d  = StArb;
                    lock_err = 1'b1;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StArb;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign req_ready = gnt;
    assign io_wen    = xfer & g_write;
    assign io_ren    = xfer & ~g_write;
    assign io_waddr  = io_wen ? g_addr  : '0;
    assign io_wdata  = io_wen ? g_wdata : '0;
    assign io_wstrb  = io_wen ? g_wstrb : '0;
    assign io_raddr  = io_ren ? g_addr  : '0;
    assign rsp_rdata = io_rdata;

    if (RD_LAT == RD_LAT_COMB) begin : g_rd_comb
        assign rsp_valid = io_ren ? gnt : '0;
    end else begin : g_rd_reg
        logic          rd_vld_q;
        logic [IW-1:0] rd_owner_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_vld_q   <= 1'b0;
                rd_owner_q <= '0;
            end else begin
                rd_vld_q   <= io_ren;
                rd_owner_q <= gidx;
            end
        end

        // Gating with rst_n drops a response whose read was accepted just before reset.
        assign rsp_valid = (rst_n && rd_vld_q) ? (NREQ'(1) << rd_owner_q) : '0;
    end

endmodule
